// File: rtl/gc_stream_pkg.sv
// Shared definitions for the garbler multi-core output stage.
// Tag encodings carried alongside every (index0, index1, data0, data1) entry,
// plus a round-robin index helper. The beat struct depends on S/K, so it is
// declared inside the modules that own those parameters.
package gc_stream_pkg;

  localparam logic [2:0] TAG_NONE = 3'b000;
  localparam logic [2:0] TAG_KEYS = 3'b001;
  localparam logic [2:0] TAG_GT   = 3'b010;
  localparam logic [2:0] TAG_MASK = 3'b011;
  localparam logic [2:0] TAG_IN0  = 3'b101;
  localparam logic [2:0] TAG_IN1  = 3'b110;
  localparam logic [2:0] TAG_IN01 = 3'b111;

  // (base + off) modulo n, for round-robin search over n channels.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/gc_chan_fifo.sv
// Per-channel synchronous FIFO, DEPTH x W.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous clear (same effect as rst)
//   push, din       write request and data; accepted when not full, or when
//                   full and popped in the same cycle
//   pop, dout       read request; dout is the current head (combinational)
//   count           occupancy, $clog2(DEPTH)+1 bits
//   full, empty     occupancy flags
module gc_chan_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);
  // When full, a same-cycle pop frees the head slot: wr_ptr == rd_ptr, and the
  // head is read combinationally before the edge overwrites it.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNTW'(wr_en) - CNTW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gc_stream_arbiter.sv
// Multi-core garbler output stage: NCH tagged streams are buffered in
// per-channel FIFOs and merged round-robin onto one valid/ready stream,
// with the source channel id appended.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               clears FIFOs, output register and RR pointer
//                       (drop_err kept)
//   in_tag/index*/data* flat per-channel inputs, channel i at slice i;
//                       tag 000 means no entry
//   in_stall            per-channel almost-full (count >= DEPTH-AF_MARGIN)
//   drop_err            sticky per-channel overflow flag, cleared by rst only
//   out_valid/out_ready output handshake
//   out_ch, out_tag, out_index0/1, out_data0/1  beat fields
module gc_stream_arbiter
  import gc_stream_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int S         = 20,
  parameter int K         = 128,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2,
  parameter int CW        = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [NCH*3-1:0] in_tag,
  input  logic [NCH*S-1:0] in_index0,
  input  logic [NCH*S-1:0] in_index1,
  input  logic [NCH*K-1:0] in_data0,
  input  logic [NCH*K-1:0] in_data1,
  output logic [NCH-1:0]   in_stall,
  output logic [NCH-1:0]   drop_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ch,
  output logic [2:0]       out_tag,
  output logic [S-1:0]     out_index0,
  output logic [S-1:0]     out_index1,
  output logic [K-1:0]     out_data0,
  output logic [K-1:0]     out_data1
);

  localparam int CNTW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [2:0]   tag;
    logic [S-1:0] index0;
    logic [S-1:0] index1;
    logic [K-1:0] data0;
    logic [K-1:0] data1;
  } gc_beat_t;

  gc_beat_t        wdata [NCH];
  gc_beat_t        head  [NCH];
  logic [CNTW-1:0] count [NCH];
  logic [NCH-1:0]  push, pop, full, empty;

  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   grant;
  logic            found;
  logic            load_en;
  gc_beat_t        out_beat;

  // Per-channel FIFOs; entries presented during flush are discarded.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign wdata[g] = '{tag:    in_tag[3*g +: 3],
                        index0: in_index0[S*g +: S],
                        index1: in_index1[S*g +: S],
                        data0:  in_data0[K*g +: K],
                        data1:  in_data1[K*g +: K]};
    assign push[g]     = (in_tag[3*g +: 3] != TAG_NONE) & ~flush;
    assign in_stall[g] = (count[g] >= CNTW'(DEPTH - AF_MARGIN));

    gc_chan_fifo #(.DEPTH(DEPTH), .W($bits(gc_beat_t)), .CNTW(CNTW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (wdata[g]),
      .dout  (head[g]),
      .count (count[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  assign load_en = ~out_valid | out_ready;

  // First non-empty channel at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NCH; off++) begin
      idx = rr_index(int'(rr_ptr), off, NCH);
      if (!found && !empty[idx]) begin
        grant = CW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load_en && found && !flush) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err <= '0;
    end else begin
      drop_err <= drop_err | (push & full & ~pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_beat  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (found) begin
        out_valid <= 1'b1;
        out_ch    <= grant;
        out_beat  <= head[grant];
        rr_ptr    <= CW'(rr_index(int'(grant), 1, NCH));
      end else begin
        out_valid <= 1'b0;  // data fields hold
      end
    end
  end

  assign out_tag    = out_beat.tag;
  assign out_index0 = out_beat.index0;
  assign out_index1 = out_beat.index1;
  assign out_data0  = out_beat.data0;
  assign out_data1  = out_beat.data1;

endmodule

// File: tb/tb_gc_stream_arbiter.sv
module tb_gc_stream_arbiter;
  import gc_stream_pkg::*;

  localparam int NCH = 4, S = 20, K = 128, DEPTH = 8, AF = 2, CW = 2;

  logic clk = 1'b0;
  logic rst, flush, out_ready;
  logic [NCH*3-1:0] in_tag;
  logic [NCH*S-1:0] in_index0, in_index1;
  logic [NCH*K-1:0] in_data0, in_data1;
  logic [NCH-1:0]   in_stall, drop_err;
  logic             out_valid;
  logic [CW-1:0]    out_ch;
  logic [2:0]       out_tag;
  logic [S-1:0]     out_index0, out_index1;
  logic [K-1:0]     out_data0, out_data1;

  always #5 clk = ~clk;

  gc_stream_arbiter #(.NCH(NCH), .S(S), .K(K), .DEPTH(DEPTH), .AF_MARGIN(AF), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_tag(in_tag), .in_index0(in_index0), .in_index1(in_index1),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_stall(in_stall), .drop_err(drop_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_tag(out_tag),
    .out_index0(out_index0), .out_index1(out_index1),
    .out_data0(out_data0), .out_data1(out_data1)
  );

  typedef struct packed {
    logic [2:0]   tag;
    logic [S-1:0] i0;
    logic [S-1:0] i1;
    logic [K-1:0] d0;
    logic [K-1:0] d1;
  } beat_t;

  // Reference model: one queue per channel, one held output beat.
  beat_t          q [NCH][$];
  beat_t          m_beat;
  logic           m_ov;
  int             m_ch, m_rr;
  logic [NCH-1:0] m_drop;
  bit             started = 0;
  int             log_ch[$];
  int             log_i0[$];

  int tests_run = 0;
  int failed    = 0;

  task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t in_beat(input int ch);
    beat_t b;
    b.tag = in_tag[3*ch +: 3];
    b.i0  = in_index0[S*ch +: S];
    b.i1  = in_index1[S*ch +: S];
    b.d0  = in_data0[K*ch +: K];
    b.d1  = in_data1[K*ch +: K];
    return b;
  endfunction

  always @(posedge clk) begin
    beat_t nb;
    int    g, c;
    bit    fnd, ld;
    int    sz [NCH];
    started = 1;
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) q[ch].delete();
      m_rr = 0; m_ov = 0; m_beat = '0; m_ch = 0; m_drop = '0;
    end else if (flush) begin
      for (int ch = 0; ch < NCH; ch++) q[ch].delete();
      m_rr = 0; m_ov = 0; m_beat = '0; m_ch = 0;
    end else begin
      ld = !m_ov || out_ready;
      if (m_ov && out_ready) begin
        log_ch.push_back(m_ch);
        log_i0.push_back(int'(m_beat.i0));
      end
      fnd = 0; g = 0; nb = '0;
      if (ld) begin
        for (int off = 0; off < NCH; off++) begin
          c = (m_rr + off) % NCH;
          if (!fnd && q[c].size() > 0) begin fnd = 1; g = c; end
        end
      end
      for (int ch = 0; ch < NCH; ch++) sz[ch] = q[ch].size();
      if (fnd) nb = q[g].pop_front();
      for (int ch = 0; ch < NCH; ch++) begin
        if (in_tag[3*ch +: 3] != 3'b000) begin
          if (sz[ch] < DEPTH || (fnd && g == ch)) q[ch].push_back(in_beat(ch));
          else m_drop[ch] = 1'b1;
        end
      end
      if (ld) begin
        if (fnd) begin
          m_ov = 1; m_beat = nb; m_ch = g; m_rr = (g + 1) % NCH;
        end else begin
          m_ov = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] st;
    if (started) begin
      for (int ch = 0; ch < NCH; ch++) st[ch] = (q[ch].size() >= DEPTH - AF);
      chki("out_valid", int'(out_valid), int'(m_ov));
      chki("out_ch", int'(out_ch), m_ch);
      chki("out_tag", int'(out_tag), int'(m_beat.tag));
      chki("out_index0", int'(out_index0), int'(m_beat.i0));
      chki("out_index1", int'(out_index1), int'(m_beat.i1));
      chk("out_data0", out_data0, m_beat.d0);
      chk("out_data1", out_data1, m_beat.d1);
      chki("in_stall", int'(in_stall), int'(st));
      chki("drop_err", int'(drop_err), int'(m_drop));
    end
  end

  task automatic clr();
    in_tag = '0; in_index0 = '0; in_index1 = '0; in_data0 = '0; in_data1 = '0;
  endtask

  task automatic put(input int ch, input logic [2:0] tag, input int i0, input logic [K-1:0] d0);
    in_tag[3*ch +: 3]    = tag;
    in_index0[S*ch +: S] = S'(i0);
    in_index1[S*ch +: S] = S'(i0 ^ 5);
    in_data0[K*ch +: K]  = d0;
    in_data1[K*ch +: K]  = ~d0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
  endtask

  function automatic logic [K-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    clr(); rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(5);
    chki("idle_valid", int'(out_valid), 0);
    chki("idle_stall", int'(in_stall), 0);
    chki("idle_drop", int'(drop_err), 0);

    // Latency: push at t, beat visible at t+2, gone at t+3.
    out_ready = 1'b1;
    put(2, TAG_GT, 4, K'(8'hA5));
    cyc(1); clr(); cyc(1);
    chki("lat_valid", int'(out_valid), 1);
    chki("lat_ch", int'(out_ch), 2);
    chki("lat_tag", int'(out_tag), 2);
    chki("lat_idx0", int'(out_index0), 4);
    chk("lat_data0", out_data0, K'(8'hA5));
    cyc(1);
    chki("lat_valid_t3", int'(out_valid), 0);

    // Round-robin burst.
    flush_pulse();
    log_ch.delete(); log_i0.delete();
    for (int k = 0; k < 3; k++) begin
      clr();
      for (int ch = 0; ch < NCH; ch++) put(ch, TAG_GT, ch*16 + k, K'(ch));
      cyc(1);
    end
    clr(); cyc(20);
    chki("rr_count", log_ch.size(), 12);
    for (int i = 0; i < 12 && i < log_ch.size(); i++) begin
      chki("rr_ch", log_ch[i], i % 4);
      chki("rr_idx", log_i0[i], (i % 4)*16 + i/4);
    end

    // Back-pressure and hold: one beat sits in the output register,
    // so seven pushes bring the FIFO count to six.
    flush_pulse();
    out_ready = 1'b0;
    log_ch.delete(); log_i0.delete();
    for (int k = 0; k < 7; k++) begin
      clr(); put(0, TAG_KEYS, 'h100 + k, rnd128()); cyc(1);
      if (k == 5) chki("bp_stall_at5", int'(in_stall[0]), 0);
      if (k == 6) chki("bp_stall_at6", int'(in_stall[0]), 1);
    end
    clr();
    chki("bp_hold_idx", int'(out_index0), 'h100);
    cyc(3);
    chki("bp_hold_idx2", int'(out_index0), 'h100);
    chki("bp_hold_valid", int'(out_valid), 1);
    out_ready = 1'b1; cyc(12);
    chki("bp_count", log_i0.size(), 7);
    for (int i = 0; i < 7 && i < log_i0.size(); i++) chki("bp_order", log_i0[i], 'h100 + i);

    // Overflow: output register + 8 FIFO slots hold nine; the rest drop.
    flush_pulse();
    out_ready = 1'b0;
    log_ch.delete(); log_i0.delete();
    for (int k = 0; k < 11; k++) begin
      clr(); put(1, TAG_MASK, 'h200 + k, rnd128()); cyc(1);
      if (k == 8) chki("ovf_no_drop_yet", int'(drop_err[1]), 0);
    end
    clr();
    chki("ovf_drop", int'(drop_err[1]), 1);
    chki("ovf_stall", int'(in_stall[1]), 1);
    out_ready = 1'b1; cyc(14);
    chki("ovf_count", log_i0.size(), 9);
    for (int i = 0; i < 9 && i < log_i0.size(); i++) chki("ovf_order", log_i0[i], 'h200 + i);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin clr(); put(1, TAG_MASK, 'h280 + k, rnd128()); cyc(1); end
    clr(); flush_pulse();
    chki("ovf_flush_valid", int'(out_valid), 0);
    chki("ovf_flush_stall", int'(in_stall), 0);
    chki("ovf_flush_drop_kept", int'(drop_err[1]), 1);
    log_ch.delete(); log_i0.delete();
    out_ready = 1'b1; cyc(5);
    chki("ovf_flush_empty", log_i0.size(), 0);

    // Full channel with simultaneous push and pop.
    flush_pulse();
    out_ready = 1'b0;
    log_ch.delete(); log_i0.delete();
    for (int k = 0; k < 9; k++) begin clr(); put(3, TAG_IN0, 'h300 + k, rnd128()); cyc(1); end
    clr();
    chki("full_no_drop", int'(drop_err[3]), 0);
    chki("full_stall", int'(in_stall[3]), 1);
    put(3, TAG_IN0, 'h3FF, rnd128()); out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0; clr();
    chki("full_pop_no_drop", int'(drop_err[3]), 0);
    put(3, TAG_IN0, 'h3FE, rnd128());
    cyc(1); clr();
    chki("full_still_full", int'(drop_err[3]), 1);
    out_ready = 1'b1; cyc(14);
    chki("full_count", log_i0.size(), 10);
    for (int i = 0; i < 9 && i < log_i0.size(); i++) chki("full_order", log_i0[i], 'h300 + i);
    if (log_i0.size() >= 10) chki("full_last", log_i0[9], 'h3FF);

    // Flush while a beat is valid; RR restarts at channel 0.
    put(1, TAG_GT, 'h401, rnd128()); put(2, TAG_GT, 'h402, rnd128());
    cyc(1); clr(); out_ready = 1'b0; cyc(1);
    chki("mid_valid_before", int'(out_valid), 1);
    flush = 1'b1;
    put(0, TAG_GT, 'h500, rnd128()); put(3, TAG_GT, 'h503, rnd128());
    cyc(1);
    flush = 1'b0; clr();
    chki("mid_valid_after", int'(out_valid), 0);
    chki("mid_stall_after", int'(in_stall), 0);
    log_ch.delete(); log_i0.delete();
    out_ready = 1'b1;
    put(3, TAG_GT, 'h513, rnd128()); put(0, TAG_GT, 'h510, rnd128());
    cyc(1); clr(); cyc(6);
    chki("mid_count", log_ch.size(), 2);
    if (log_ch.size() >= 2) begin
      chki("mid_first", log_ch[0], 0);
      chki("mid_second", log_ch[1], 3);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      clr();
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 2) == 0)
          put(ch, 3'($urandom_range(1, 7)), int'($urandom_range(0, 1 << 20)), rnd128());
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    clr(); flush = 1'b0; out_ready = 1'b1;
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
